// File: rtl/cpu_irq_pkg.sv
// Shared types and constants for the interrupt arbiter: FSM states, line count
// and bit positions inside the {nmi, irq[3:0]} pending vector.
package cpu_irq_pkg;

    localparam int unsigned NUM_IRQ  = 4;
    localparam int unsigned PEND_IRQ = 0;
    localparam int unsigned PEND_NMI = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational maskable-line selector: the first set request found when
// scanning upward from ptr (wrapping) wins; ptr = 0 gives irq[0]-highest order.
module irq_prio_sel
    import cpu_irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic               valid,
    output logic [1:0]         idx
);

    logic [1:0] cand;

    // Scan from the lowest priority up so the highest-priority hit is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            cand = ptr + 2'(NUM_IRQ - 1 - i);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: edge-latched NMI + 4 maskable lines, IDLE/GRANT/SERVICE handshake.
// Define INTERRUPT_ARBITER_ROUND_ROBIN_EN for rotating priority among maskable lines.
module interrupt_arbiter
    import cpu_irq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] irq,
    input  logic       nmi,
    input  logic       int_dis,
    input  logic [3:0] irq_mask,
    input  logic       poll,
    input  logic       ack,
    input  logic       eoi,
    output logic       int_req,
    output logic       int_is_nmi,
    output logic [1:0] int_id,
    output logic       in_service,
    output logic [4:0] pending
);

    state_t     state, state_nx;
    logic [3:0] irq_q;
    logic       nmi_q;
    logic [4:0] pend_set, pend_clr;
    logic [3:0] sel_req;
    logic       sel_valid;
    logic [1:0] sel_idx;
    logic [1:0] rr_ptr;
    logic       eligible;
    logic       nmi_nx;
    logic [1:0] id_nx;

    assign pend_set = {nmi & ~nmi_q, irq & ~irq_q};
    assign sel_req  = pending[PEND_IRQ +: NUM_IRQ] & irq_mask & {NUM_IRQ{~int_dis}};
    assign eligible = pending[PEND_NMI] | sel_valid;

    assign int_req    = (state == GRANT);
    assign in_service = (state == SERVICE);

    irq_prio_sel u_sel (
        .req   (sel_req),
        .ptr   (rr_ptr),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    always_comb begin
        state_nx = state;
        nmi_nx   = int_is_nmi;
        id_nx    = int_id;
        pend_clr = '0;
        case (state)
            IDLE: begin
                if (poll && eligible) begin
                    state_nx = GRANT;
                    if (pending[PEND_NMI]) begin
                        nmi_nx = 1'b1;
                        id_nx  = '0;
                    end else begin
                        nmi_nx = 1'b0;
                        id_nx  = sel_idx;
                    end
                end
            end
            GRANT: begin
                if (ack) begin
                    state_nx = SERVICE;
                    if (int_is_nmi)
                        pend_clr[PEND_NMI] = 1'b1;
                    else
                        pend_clr[int_id] = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_nx = IDLE;
                    nmi_nx   = 1'b0;
                    id_nx    = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Edge registers reload from live inputs in reset so held levels never latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pending    <= '0;
            int_is_nmi <= 1'b0;
            int_id     <= '0;
            irq_q      <= irq;
            nmi_q      <= nmi;
        end else begin
            state      <= state_nx;
            pending    <= (pending & ~pend_clr) | pend_set;
            int_is_nmi <= nmi_nx;
            int_id     <= id_nx;
            irq_q      <= irq;
            nmi_q      <= nmi;
        end
    end

`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (state == GRANT && ack && !int_is_nmi)
            rr_ptr <= int_id + 2'd1;
    end
`else
    assign rr_ptr = '0;
`endif

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Scoreboard bench for interrupt_arbiter: expectations are queued with each
// stimulus step and compared against DUT outputs one cycle later.
module tb_interrupt_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq;
    logic       nmi;
    logic       int_dis;
    logic [3:0] irq_mask;
    logic       poll;
    logic       ack;
    logic       eoi;
    logic       int_req;
    logic       int_is_nmi;
    logic [1:0] int_id;
    logic       in_service;
    logic [4:0] pending;

    interrupt_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .nmi        (nmi),
        .int_dis    (int_dis),
        .irq_mask   (irq_mask),
        .poll       (poll),
        .ack        (ack),
        .eoi        (eoi),
        .int_req    (int_req),
        .int_is_nmi (int_is_nmi),
        .int_id     (int_id),
        .in_service (in_service),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {F_REQ, F_NMI, F_ID, F_SVC, F_PEND} fld_t;
    typedef struct {
        fld_t       fld;
        logic [4:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [4:0] act, input logic [4:0] exp_v);
        n_checks++;
        if (act === exp_v)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
    endtask

    task automatic expect_o(input fld_t f, input logic [4:0] v, input string tag);
        exp_t e;
        e.fld = f;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        logic [4:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.fld)
                F_REQ:   act = {4'b0, int_req};
                F_NMI:   act = {4'b0, int_is_nmi};
                F_ID:    act = {3'b0, int_id};
                F_SVC:   act = {4'b0, in_service};
                default: act = pending;
            endcase
            check(e.tag, act, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // One full poll -> grant -> ack -> eoi round with the expected winner.
    task automatic serve(input logic exp_nmi, input logic [1:0] exp_id, input string tag);
        poll = 1'b1;
        expect_o(F_REQ, 5'd1, {tag, "_req"});
        expect_o(F_NMI, {4'b0, exp_nmi}, {tag, "_nmi"});
        expect_o(F_ID, {3'b0, exp_id}, {tag, "_id"});
        tick();
        poll = 1'b0;
        ack  = 1'b1;
        expect_o(F_SVC, 5'd1, {tag, "_svc"});
        expect_o(F_REQ, 5'd0, {tag, "_reqdrop"});
        tick();
        ack = 1'b0;
        eoi = 1'b1;
        expect_o(F_SVC, 5'd0, {tag, "_eoi"});
        expect_o(F_ID, 5'd0, {tag, "_idle_id"});
        tick();
        eoi = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        irq      = '0;
        nmi      = 1'b0;
        int_dis  = 1'b0;
        irq_mask = 4'hF;
        poll     = 1'b0;
        ack      = 1'b0;
        eoi      = 1'b0;
        tick();
        expect_o(F_REQ, 5'd0, "rst_req");
        expect_o(F_NMI, 5'd0, "rst_nmi");
        expect_o(F_ID, 5'd0, "rst_id");
        expect_o(F_SVC, 5'd0, "rst_svc");
        expect_o(F_PEND, 5'd0, "rst_pend");
        tick();
        rst = 1'b0;
        tick();

        // single maskable line 2
        irq = 4'b0100;
        expect_o(F_PEND, 5'b00100, "s1_pend");
        tick();
        poll = 1'b1;
        expect_o(F_REQ, 5'd1, "s1_req");
        expect_o(F_ID, 5'd2, "s1_id");
        tick();
        poll = 1'b0;
        ack  = 1'b1;
        expect_o(F_SVC, 5'd1, "s1_svc");
        expect_o(F_PEND, 5'd0, "s1_pendclr");
        tick();
        ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        irq = '0;
        tick();

        // NMI and two lines together: NMI wins, then line 1, then line 3
        do_reset();
        irq = 4'b1010;
        nmi = 1'b1;
        expect_o(F_PEND, 5'b11010, "s2_pend");
        tick();
        serve(1'b1, 2'd0, "s2_nmi");
        expect_o(F_PEND, 5'b01010, "s2_pend_after");
        tick();
        serve(1'b0, 2'd1, "s2_l1");
        serve(1'b0, 2'd3, "s2_l3");
        irq = '0;
        nmi = 1'b0;
        tick();

        // int_dis blocks maskable, not NMI
        do_reset();
        int_dis = 1'b1;
        irq     = 4'b0001;
        expect_o(F_PEND, 5'b00001, "s3_pend");
        tick();
        poll = 1'b1;
        expect_o(F_REQ, 5'd0, "s3_blocked");
        tick();
        nmi = 1'b1;
        expect_o(F_REQ, 5'd0, "s3_blocked2");
        expect_o(F_PEND, 5'b10001, "s3_pend_nmi");
        tick();
        poll = 1'b0;
        serve(1'b1, 2'd0, "s3_nmi");
        int_dis = 1'b0;
        nmi     = 1'b0;
        serve(1'b0, 2'd0, "s3_l0");
        irq = '0;
        tick();

        // new request during SERVICE waits for eoi; poll ignored in SERVICE
        do_reset();
        irq = 4'b0001;
        tick();
        poll = 1'b1;
        expect_o(F_ID, 5'd0, "s4_id0");
        tick();
        poll = 1'b0;
        ack  = 1'b1;
        tick();
        ack = 1'b0;
        irq = 4'b1001;
        expect_o(F_PEND, 5'b01000, "s4_pend");
        expect_o(F_SVC, 5'd1, "s4_svc");
        tick();
        poll = 1'b1;
        expect_o(F_REQ, 5'd0, "s4_nonest");
        expect_o(F_SVC, 5'd1, "s4_svc_hold");
        tick();
        poll = 1'b0;
        eoi  = 1'b1;
        expect_o(F_SVC, 5'd0, "s4_eoi");
        tick();
        eoi = 1'b0;
        serve(1'b0, 2'd3, "s4_l3");
        irq = '0;
        tick();

        // masked line not granted; unmasked neighbour is
        do_reset();
        irq_mask = 4'b1110;
        irq      = 4'b0001;
        tick();
        poll = 1'b1;
        expect_o(F_REQ, 5'd0, "s5_masked");
        tick();
        poll = 1'b0;
        irq  = 4'b0011;
        expect_o(F_PEND, 5'b00011, "s5_pend");
        tick();
        serve(1'b0, 2'd1, "s5_l1");
        irq_mask = 4'hF;
        serve(1'b0, 2'd0, "s5_l0");
        irq = '0;
        tick();

        // lines 0 and 1 re-pulsed before every round
        do_reset();
        for (int unsigned r = 0; r < 4; r++) begin
            irq = 4'b0011;
            tick();
`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
            serve(1'b0, 2'(r % 2), "s6_rr");
`else
            serve(1'b0, 2'd0, "s6_fix");
`endif
            irq = '0;
            tick();
        end
`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
        serve(1'b0, 2'd0, "s6_drain");
`else
        serve(1'b0, 2'd1, "s6_drain");
`endif

        // reset during GRANT and SERVICE aborts; held level raises nothing
        do_reset();
        irq = 4'b0100;
        tick();
        poll = 1'b1;
        expect_o(F_REQ, 5'd1, "s7_grant");
        tick();
        poll = 1'b0;
        rst  = 1'b1;
        expect_o(F_REQ, 5'd0, "s7_rst_req");
        expect_o(F_PEND, 5'd0, "s7_rst_pend");
        expect_o(F_ID, 5'd0, "s7_rst_id");
        tick();
        rst = 1'b0;
        expect_o(F_PEND, 5'd0, "s7_held");
        tick();
        poll = 1'b1;
        expect_o(F_REQ, 5'd0, "s7_nogrant");
        tick();
        poll = 1'b0;
        irq  = 4'b0000;
        tick();
        irq = 4'b0100;
        tick();
        poll = 1'b1;
        tick();
        poll = 1'b0;
        ack  = 1'b1;
        expect_o(F_SVC, 5'd1, "s7_svc");
        tick();
        ack = 1'b0;
        rst = 1'b1;
        expect_o(F_SVC, 5'd0, "s7_rst_svc");
        expect_o(F_PEND, 5'd0, "s7_rst_pend2");
        tick();
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 SHALL have port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port `rst`: input, 1 bit, reset, synchronous and active-high.
REQ-003 SHALL have port `irq`: input, 4 bits, maskable request lines; a rising edge latches a request.
REQ-004 SHALL have port `nmi`: input, 1 bit, non-maskable request; a rising edge latches a request.
REQ-005 SHALL have port `int_dis`: input, 1 bit, 1 blocks selection of maskable requests (INTD equivalent); no effect on NMI.
REQ-006 SHALL have port `irq_mask`: input, 4 bits, per-line enable (1 = enabled).
REQ-007 SHALL have port `poll`: input, 1 bit, high while the CPU controller is in its pre-fetch state.
REQ-008 SHALL have port `ack`: input, 1 bit, controller has entered its interrupt state.
REQ-009 SHALL have port `eoi`: input, 1 bit, end of interrupt service.
REQ-010 SHALL have port `int_req`: output, 1 bit, interrupt granted, awaiting `ack`.
REQ-011 SHALL have port `int_is_nmi`: output, 1 bit, current grant is the NMI.
REQ-012 SHALL have port `int_id`: output, 2 bits, granted maskable line index; 0 when `int_is_nmi`=1.
REQ-013 SHALL have port `in_service`: output, 1 bit, a grant has been acknowledged and is not yet ended.
REQ-014 SHALL have port `pending`: output, 5 bits, latched requests: {nmi, irq[3:0]}.

Function
REQ-015 SHALL detect edges against registered previous values; `pending` bit is set in the cycle after `irq[i]`/`nmi` is first sampled high.
REQ-016 SHALL let the set of a `pending` bit dominate its clear in the same cycle; the bit stays 1.
REQ-017 SHALL treat the block as eligible when `pending[4]` is 1, or when `int_dis` is 0 and any bit of `pending[3:0] & irq_mask` is 1.
REQ-018 SHALL implement states IDLE, GRANT and SERVICE.
REQ-019 SHALL, in IDLE with `poll`=1 and eligible, select a winner, register it and move to GRANT; with no eligible request, stay in IDLE and keep `int_req`=0.
REQ-020 SHALL select by priority: NMI first, then maskable lines by fixed priority with irq[0] highest (REQ-028 gives the alternative).
REQ-021 SHALL, in GRANT, hold `int_req`=1 and keep `int_is_nmi`/`int_id` stable until `ack`; later changes on `int_dis` or `irq_mask` SHALL NOT revoke the grant.
REQ-022 SHALL, on `ack` in GRANT, clear the granted pending bit, move to SERVICE and drop `int_req` in the next cycle.
REQ-023 SHALL, in SERVICE, hold `in_service`=1 with no new grant (no nesting; an NMI arriving here stays pending), and move to IDLE on `eoi`.
REQ-024 SHALL ignore `ack` outside GRANT, `eoi` outside SERVICE, and `poll` outside IDLE.
REQ-025 SHALL keep `int_id`/`int_is_nmi` at their last grant value in SERVICE and at 0 in IDLE.

Reset
REQ-026 SHALL, with `rst`=1, go to IDLE, clear `pending`, `int_req`, `int_is_nmi`, `int_id`, `in_service` and the rotation pointer to 0, and load the edge-detect registers with the current inputs so that a level already high raises no request.
REQ-027 SHALL let `rst` asserted in GRANT or SERVICE abort the grant with no request retained.

Configuration
REQ-028 SHALL compile rotating priority among maskable lines when `INTERRUPT_ARBITER_ROUND_ROBIN_EN` is defined: a 2-bit pointer marks the highest-priority line and moves to (granted id + 1) mod 4 on `ack`; NMI remains highest. Without the macro, fixed priority per REQ-020 applies and no pointer register exists.

Structure
REQ-029 SHALL place the state enum, the constant NUM_IRQ=4 and the `pending` bit positions in a shared package `cpu_irq_pkg`.
REQ-030 SHALL place the maskable-line selection in a combinational sub-module `irq_prio_sel` (inputs: request vector and pointer; outputs: valid and index).

Verification
REQ-031 SHALL check: `irq`=4'b0100, `irq_mask`=4'hF, `poll`=1 → `int_req`=1, `int_id`=2; after `ack`, `in_service`=1 and `pending`=0.
REQ-032 SHALL check: `irq`=4'b1010 and `nmi` rising in the same cycle, then `poll` → `int_is_nmi`=1 first; after `eoi` and `poll`, `int_id`=1.
REQ-033 SHALL check: `int_dis`=1 with `pending[0]`=1 → `poll` gives no `int_req`; with `int_dis`=1 and `nmi` edge → NMI is granted.
REQ-034 SHALL check: `irq[3]` edge during SERVICE → no grant until `eoi`; the next `poll` grants `int_id`=3.
REQ-035 SHALL check, with ROUND_ROBIN_EN: lines 0 and 1 held pending, repeated grant/ack/eoi cycles → ids 0,1,0,1; without the macro → ids 0,0.
REQ-036 SHALL check: `rst` pulse in GRANT → IDLE next cycle, `int_req`=0, `pending`=0; `irq` held high through reset gives no request.
